apb_uart_master: RTL and testbench

//  APB requester that drives the UART register map (DATA 0x0, CTRL 0x4, STAT 0x8, INT 0xC).

---
 rtl/apb_uart_master.sv | 101 ++++++++++
 tb/tb_apb_uart_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_uart_master.sv
// apb_uart_master: APB requester that turns a valid/ready command into one APB transfer
//   towards the UART register map (DATA 0x0, CTRL 0x4, STAT 0x8, INT 0xC).
// Ports:
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake, accepted when both high at a PCLK edge
//   cmd_write/cmd_addr/cmd_wdata   direction, register address, write data
//   rsp_valid                      one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout  read data, error (PSLVERR or timeout), watchdog abort flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request signals (registered)
//   PREADY/PRDATA/PSLVERR          APB completion signals, sampled only in ACCESS
module apb_uart_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = TIMEOUT_CYCLES != 0;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  // cmd_ready is gated by PRESETn so nothing is accepted while reset is asserted.
  assign cmd_ready   = (state == IDLE) & PRESETn;
  assign timeout_hit = WD_EN && (wait_cnt == LAST);
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          state   <= SETUP;
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          PWRITE  <= cmd_write;
          PADDR   <= cmd_addr;
          PWDATA  <= cmd_wdata;
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: if (PREADY) begin
          state       <= IDLE;
          PSEL        <= 1'b0;
          PENABLE     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= PWRITE ? '0 : PRDATA;
          rsp_err     <= PSLVERR;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          state       <= IDLE;
          PSEL        <= 1'b0;
          PENABLE     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end else if (wait_cnt != '1) begin
          // saturating wait-state count; never wraps back into the timeout window
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: table, hand-written and randomized checks of apb_uart_master
module tb_apb_uart_master;
  localparam int T = 16;
  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [15:0] PWDATA;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [15:0] PRDATA = '0;
  int n_cmp = 0, n_bad = 0;

  apb_uart_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic w; logic [3:0] a; logic [15:0] d; int waits; logic se; logic [15:0] rd;
    int lat; logic [15:0] erd; logic eerr; logic eto;
  } vec_t;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  // Reference: a transfer finishes on ACCESS cycle waits+1, unless T wait cycles come first.
  function automatic vec_t model(logic w, logic [3:0] a, logic [15:0] d, int waits, logic se, logic [15:0] rd);
    vec_t v;
    bit to = waits >= T;
    v.w = w; v.a = a; v.d = d; v.waits = waits; v.se = se; v.rd = rd;
    v.lat  = to ? T + 2 : waits + 3;
    v.eto  = to;
    v.eerr = to | se;
    v.erd  = (w || to) ? 16'h0 : rd;
    return v;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the response pulse.
  task automatic run_xfer(input vec_t v, input string tag);
    int c = 0, setups = 0, accs = 0, bad = 0;
    bit done = 0;
    logic [15:0] got_rd = '0;
    logic got_err = 0, got_to = 0;
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.w; cmd_addr = v.a; cmd_wdata = v.d;
    @(posedge PCLK); #1;
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 16'($urandom);
    while (!done && c < 40) begin
      @(negedge PCLK); c++;
      if (rsp_valid) begin
        done = 1; got_rd = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
        chk({tag, "_psel_at_rsp"}, PSEL, 0);
        PREADY = 1;
      end else begin
        if (PSEL && !PENABLE) setups++;
        if (PSEL && PENABLE) accs++;
        if (PSEL && (PADDR !== v.a || PWRITE !== v.w || PWDATA !== v.d)) bad++;
        if (PSEL && PENABLE) begin
          PREADY  = accs > v.waits;
          PRDATA  = PREADY ? v.rd : 16'($urandom);
          PSLVERR = PREADY ? v.se : 1'($urandom);
        end else begin
          PREADY = 1'($urandom); PRDATA = 16'($urandom); PSLVERR = 1'($urandom);
        end
      end
    end
    chk({tag, "_latency"}, c, v.lat);
    chk({tag, "_rdata"}, got_rd, v.erd);
    chk({tag, "_err"}, got_err, v.eerr);
    chk({tag, "_timeout"}, got_to, v.eto);
    chk({tag, "_setup_cycles"}, setups, 1);
    chk({tag, "_access_cycles"}, accs, v.lat - 2);
    chk({tag, "_stable_addr_data"}, bad, 0);
    @(negedge PCLK);
    chk({tag, "_single_pulse"}, rsp_valid, 0);
    chk({tag, "_idle_psel"}, PSEL, 0);
    PREADY = 0;
  endtask

  vec_t tbl[6];
  logic [3:0]  ba[3];
  logic [15:0] bd[3];

  initial begin
    tbl[0] = '{w:1, a:4'h4, d:16'h0015, waits:0,   se:0, rd:16'h0000, lat:3,  erd:16'h0,    eerr:0, eto:0};
    tbl[1] = '{w:0, a:4'h8, d:16'h0000, waits:3,   se:0, rd:16'h0021, lat:6,  erd:16'h0021, eerr:0, eto:0};
    tbl[2] = '{w:0, a:4'h0, d:16'h0000, waits:0,   se:1, rd:16'hBEEF, lat:3,  erd:16'hBEEF, eerr:1, eto:0};
    tbl[3] = '{w:0, a:4'hC, d:16'h0000, waits:100, se:0, rd:16'h1234, lat:18, erd:16'h0,    eerr:1, eto:1};
    tbl[4] = '{w:0, a:4'h8, d:16'h0000, waits:15,  se:0, rd:16'h5A5A, lat:18, erd:16'h5A5A, eerr:0, eto:0};
    tbl[5] = '{w:1, a:4'h0, d:16'hA55A, waits:2,   se:1, rd:16'hFFFF, lat:5,  erd:16'h0,    eerr:1, eto:0};
    ba = '{4'h0, 4'h4, 4'hC};
    bd = '{16'h1111, 16'h2222, 16'h3333};

    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    PRESETn = 1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    begin
      int k = 0, low = 0, cyc = 0;
      bit prev = 0, seen = 0;
      logic [3:0]  qa[$];
      logic [15:0] qd[$];
      cmd_valid = 1; cmd_write = 1; cmd_addr = ba[0]; cmd_wdata = bd[0];
      while (k < 3 && cyc < 40) begin
        @(negedge PCLK); cyc++;
        if (PSEL && !PENABLE) begin qa.push_back(PADDR); qd.push_back(PWDATA); end
        if (PSEL && !prev) begin
          if (seen) chk("b2b_gap", low, 1);
          seen = 1;
        end
        low  = PSEL ? 0 : low + 1;
        prev = PSEL;
        PREADY = PSEL && PENABLE;
        if (rsp_valid) begin
          k++;
          if (k < 3) begin cmd_addr = ba[k]; cmd_wdata = bd[k]; end
          else cmd_valid = 0;
        end
      end
      chk("b2b_count", k, 3);
      chk("b2b_setups", qa.size(), 3);
      for (int i = 0; i < 3 && i < qa.size(); i++) begin
        chk($sformatf("b2b_addr%0d", i), qa[i], ba[i]);
        chk($sformatf("b2b_data%0d", i), qd[i], bd[i]);
      end
      PREADY = 0;
      @(negedge PCLK);
    end

    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h8;
    @(posedge PCLK); #1 cmd_valid = 0;
    PREADY = 0;
    repeat (2) @(negedge PCLK);
    chk("rst_mid_in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 0;
    #1;
    chk("rst_mid_psel_penable", {PSEL, PENABLE}, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    begin
      int pulses = 0;
      PREADY = 1;
      repeat (3) begin @(negedge PCLK); pulses += int'(rsp_valid); end
      PRESETn = 1;
      PREADY = 0;
      repeat (2) begin @(negedge PCLK); pulses += int'(rsp_valid); end
      chk("rst_mid_no_rsp", pulses, 0);
    end
    run_xfer(model(0, 4'h4, 16'h0, 1, 0, 16'h00C3), "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic w = 1'($urandom);
      int waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 22) : $urandom_range(0, 5);
      run_xfer(model(w, 4'($urandom_range(0, 3) * 4), 16'($urandom), waits, 1'($urandom), 16'($urandom)),
               $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
